// File: rtl/sound_scheduler.sv
// sound_scheduler: arbitrates ball/brick sound requests onto the single sine-ROM tone path,
// playing one note (or the 3-note life-lost melody) through timed PLAY and GAP phases.
module sound_scheduler #(
    parameter logic [31:0] STEP_C   = 32'd2986,
    parameter logic [31:0] STEP_D   = 32'd2660,
    parameter logic [31:0] STEP_E   = 32'd2369,
    parameter logic [31:0] STEP_G   = 32'd1993,
    parameter logic [31:0] NOTE_LEN = 32'd5000000,
    parameter logic [31:0] GAP_LEN  = 32'd500000
) (
    input  logic       clk,
    input  logic       reset_button,
    input  logic       enable,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] note,
    output logic [4:0] sample_addr,
    output logic       sample_strobe,
    output logic       tone_on,
    output logic       busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] NOTE_C = 2'd0;
    localparam logic [1:0] NOTE_D = 2'd1;
    localparam logic [1:0] NOTE_E = 2'd2;
    localparam logic [1:0] NOTE_G = 2'd3;

    state_t      state_q, state_d;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  note_q, note_d;
    logic [1:0]  mel_idx_q, mel_idx_d;
    logic        melody_q, melody_d;
    logic [4:0]  addr_q, addr_d;
    logic        strobe_q, strobe_d;
    logic        tone_q, tone_d;
    logic [11:0] step_q, step_d;
    logic [22:0] dur_q, dur_d;

    logic [31:0] step_len;
    logic        step_end, dur_end, gap_end;
    logic [3:0]  arb;
    logic        start;

    function automatic logic [1:0] melody_note(input logic [1:0] idx);
        case (idx)
            2'd0:    return NOTE_G;
            2'd1:    return NOTE_E;
            default: return NOTE_C;
        endcase
    endfunction

    function automatic logic [1:0] source_note(input logic [3:0] onehot);
        if (onehot[3])      return NOTE_G;
        else if (onehot[2]) return NOTE_C;
        else if (onehot[1]) return NOTE_E;
        else                return NOTE_G;
    endfunction

    always_comb begin
        step_len = STEP_C;
        case (note_q)
            NOTE_C:  step_len = STEP_C;
            NOTE_D:  step_len = STEP_D;
            NOTE_E:  step_len = STEP_E;
            default: step_len = STEP_G;
        endcase
        step_end = ({20'd0, step_q} == step_len - 32'd1);
        dur_end  = ({9'd0, dur_q} == NOTE_LEN - 32'd1);
        gap_end  = ({9'd0, dur_q} == GAP_LEN - 32'd1);
    end

    // Fixed priority 3 > 2 > 1 > 0; a pending melody may also cut a single note short.
    always_comb begin
        arb = 4'b0000;
        if (pending_q[3])      arb = 4'b1000;
        else if (pending_q[2]) arb = 4'b0100;
        else if (pending_q[1]) arb = 4'b0010;
        else if (pending_q[0]) arb = 4'b0001;
        if (state_q == ST_IDLE) start = enable && (pending_q != 4'b0000);
        else                    start = enable && pending_q[3] && !melody_q;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = 4'b0000;
        note_d    = note_q;
        mel_idx_d = mel_idx_q;
        melody_d  = melody_q;
        addr_d    = addr_q;
        strobe_d  = 1'b0;
        tone_d    = tone_q;
        step_d    = step_q;
        dur_d     = dur_q;

        if (!enable) begin
            state_d   = ST_IDLE;
            tone_d    = 1'b0;
            addr_d    = 5'd0;
            step_d    = 12'd0;
            dur_d     = 23'd0;
            melody_d  = 1'b0;
            mel_idx_d = 2'd0;
        end else if (start) begin
            state_d   = ST_PLAY;
            grant_d   = arb;
            note_d    = source_note(arb);
            melody_d  = arb[3];
            mel_idx_d = 2'd0;
            addr_d    = 5'd0;
            step_d    = 12'd0;
            dur_d     = 23'd0;
            tone_d    = 1'b1;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    // The final note cycle never advances the address, so no strobe leaks into GAP.
                    if (dur_end) begin
                        state_d = ST_GAP;
                        tone_d  = 1'b0;
                        step_d  = 12'd0;
                        dur_d   = 23'd0;
                    end else begin
                        dur_d = dur_q + 23'd1;
                        if (step_end) begin
                            step_d   = 12'd0;
                            addr_d   = addr_q + 5'd1;
                            strobe_d = 1'b1;
                        end else begin
                            step_d = step_q + 12'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        dur_d = 23'd0;
                        if (melody_q && (mel_idx_q != 2'd2)) begin
                            state_d   = ST_PLAY;
                            mel_idx_d = mel_idx_q + 2'd1;
                            note_d    = melody_note(mel_idx_q + 2'd1);
                            addr_d    = 5'd0;
                            step_d    = 12'd0;
                            tone_d    = 1'b1;
                        end else begin
                            state_d  = ST_IDLE;
                            melody_d = 1'b0;
                        end
                    end else begin
                        dur_d = dur_q + 23'd1;
                    end
                end
                default: ;
            endcase
        end

        // A request arriving in its own grant cycle survives the clear.
        pending_d = enable ? ((pending_q & ~grant_d) | req) : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            state_q   <= ST_IDLE;
            pending_q <= 4'b0000;
            grant_q   <= 4'b0000;
            note_q    <= 2'd0;
            mel_idx_q <= 2'd0;
            melody_q  <= 1'b0;
            addr_q    <= 5'd0;
            strobe_q  <= 1'b0;
            tone_q    <= 1'b0;
            step_q    <= 12'd0;
            dur_q     <= 23'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            note_q    <= note_d;
            mel_idx_q <= mel_idx_d;
            melody_q  <= melody_d;
            addr_q    <= addr_d;
            strobe_q  <= strobe_d;
            tone_q    <= tone_d;
            step_q    <= step_d;
            dur_q     <= dur_d;
        end
    end

    assign grant         = grant_q;
    assign note          = note_q;
    assign sample_addr   = addr_q;
    assign sample_strobe = strobe_q;
    assign tone_on       = tone_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: table vectors, hand-written corner sequences and random traffic,
// all checked every cycle against a timeline model of the sound schedule.
module tb_sound_scheduler;
    localparam int N   = 64;
    localparam int GP  = 8;
    localparam int PER = N + GP;

    logic       clk = 1'b0;
    logic       reset_button = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] grant;
    logic [1:0] note;
    logic [4:0] sample_addr;
    logic       sample_strobe, tone_on, busy;

    logic       enable_w = 1'b0;
    logic [3:0] req_w = 4'b0;
    logic [3:0] grant_w;
    logic [1:0] note_w;
    logic [4:0] sample_addr_w;
    logic       sample_strobe_w, tone_on_w, busy_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sound_scheduler #(.STEP_C(32'd7), .STEP_D(32'd6), .STEP_E(32'd5), .STEP_G(32'd4),
                      .NOTE_LEN(32'd64), .GAP_LEN(32'd8)) u_dut (
        .clk(clk), .reset_button(reset_button), .enable(enable), .req(req),
        .grant(grant), .note(note), .sample_addr(sample_addr),
        .sample_strobe(sample_strobe), .tone_on(tone_on), .busy(busy));

    // Longer note so the 5-bit address is seen wrapping 31 -> 0.
    sound_scheduler #(.STEP_C(32'd7), .STEP_D(32'd6), .STEP_E(32'd5), .STEP_G(32'd4),
                      .NOTE_LEN(32'd200), .GAP_LEN(32'd8)) u_wrap (
        .clk(clk), .reset_button(reset_button), .enable(enable_w), .req(req_w),
        .grant(grant_w), .note(note_w), .sample_addr(sample_addr_w),
        .sample_strobe(sample_strobe_w), .tone_on(tone_on_w), .busy(busy_w));

    // Model: which source is sounding and how many cycles into its schedule it is.
    int         m_cur;
    int         m_t;
    logic [3:0] m_pend;
    logic       m_started;
    logic [1:0] m_note;
    logic [4:0] m_addr;
    logic [3:0] e_grant;
    logic       e_strobe, e_tone, e_busy;
    logic [3:0] glog[$];

    typedef struct {
        logic [3:0] r;
        logic [3:0] g;
        logic [1:0] n;
        int         ngr;
        logic [3:0] glast;
    } vec_t;

    function automatic int step_of(input logic [1:0] n);
        case (n)
            2'd0:    return 7;
            2'd1:    return 6;
            2'd2:    return 5;
            default: return 4;
        endcase
    endfunction

    function automatic int sound_len(input int src);
        return (src == 3) ? 3 * PER : PER;
    endfunction

    function automatic logic [1:0] note_at(input int src, input int k);
        if (src == 3) return (k == 0) ? 2'd3 : ((k == 1) ? 2'd2 : 2'd0);
        if (src == 2) return 2'd0;
        if (src == 1) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [3:0] last_grant();
        if (glog.size() == 0) return 4'b0;
        return glog[glog.size() - 1];
    endfunction

    function automatic logic [15:0] log_pack();
        logic [15:0] v;
        v = 16'h0;
        for (int i = 0; i < glog.size() && i < 4; i++) v[15 - 4 * i -: 4] = glog[i];
        return v;
    endfunction

    task automatic m_reset();
        m_cur = -1; m_t = 0; m_pend = 4'b0; m_started = 1'b0;
        m_note = 2'd0; m_addr = 5'd0;
        e_grant = 4'b0; e_strobe = 1'b0; e_tone = 1'b0; e_busy = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [3:0] r);
        int start, p, k, st;
        start = -1;
        m_started = 1'b0;
        if (!en) begin
            m_cur = -1; m_pend = 4'b0; m_addr = 5'd0;
        end else begin
            if (m_cur < 0) begin
                if (m_pend[3])      start = 3;
                else if (m_pend[2]) start = 2;
                else if (m_pend[1]) start = 1;
                else if (m_pend[0]) start = 0;
            end else if (m_cur != 3 && m_pend[3]) begin
                start = 3;
            end
            if (start >= 0) begin
                m_cur = start; m_t = 0; m_pend[start] = 1'b0; m_started = 1'b1;
            end else if (m_cur >= 0) begin
                m_t++;
                if (m_t == sound_len(m_cur)) m_cur = -1;
            end
            m_pend = m_pend | r;
        end
        e_grant  = m_started ? 4'(1 << m_cur) : 4'b0;
        e_busy   = (m_cur >= 0);
        e_tone   = 1'b0;
        e_strobe = 1'b0;
        if (m_cur >= 0) begin
            p = m_t % PER;
            k = m_t / PER;
            m_note = note_at(m_cur, k);
            st = step_of(m_note);
            m_addr = 5'(((p < N) ? p : N - 1) / st);
            e_tone = (p < N);
            e_strobe = (p < N) && (p > 0) && (p % st == 0);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic tick(input logic en, input logic [3:0] r);
        enable = en;
        req = r;
        @(posedge clk);
        model_step(en, r);
        #1;
        if (grant != 4'b0) glog.push_back(grant);
        tests++;
        if ({grant, note, sample_addr, sample_strobe, tone_on, busy} !==
            {e_grant, m_note, m_addr, e_strobe, e_tone, e_busy}) begin
            fails++;
            $display("FAIL cycle @%0t: grant=%b note=%0d addr=%0d strobe=%b tone=%b busy=%b, want grant=%b note=%0d addr=%0d strobe=%b tone=%b busy=%b",
                     $time, grant, note, sample_addr, sample_strobe, tone_on, busy,
                     e_grant, m_note, m_addr, e_strobe, e_tone, e_busy);
        end
    endtask

    task automatic run_idle();
        for (int i = 0; i < 3000 && (m_cur >= 0 || m_pend != 4'b0); i++) tick(1'b1, 4'b0);
        tick(1'b1, 4'b0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t tbl[7];
        int   cnt;
        tbl[0] = '{4'b0001, 4'b0001, 2'd3, 1, 4'b0001};
        tbl[1] = '{4'b0010, 4'b0010, 2'd2, 1, 4'b0010};
        tbl[2] = '{4'b0100, 4'b0100, 2'd0, 1, 4'b0100};
        tbl[3] = '{4'b0101, 4'b0100, 2'd0, 2, 4'b0001};
        tbl[4] = '{4'b1000, 4'b1000, 2'd3, 1, 4'b1000};
        tbl[5] = '{4'b0110, 4'b0100, 2'd0, 2, 4'b0010};
        tbl[6] = '{4'b1111, 4'b1000, 2'd3, 4, 4'b0001};

        m_reset();
        #1 reset_button = 1'b0;
        #1 check("reset_outputs", 32'({grant, note, sample_addr, sample_strobe, tone_on, busy}), 32'd0);
        @(posedge clk);
        #1 reset_button = 1'b1;
        enable_w = 1'b1;

        // Single requests and simultaneous requests from idle.
        for (int i = 0; i < 7; i++) begin
            glog.delete();
            tick(1'b1, tbl[i].r);
            tick(1'b1, 4'b0);
            check("tbl_grant", 32'(grant), 32'(tbl[i].g));
            check("tbl_note", 32'(note), 32'(tbl[i].n));
            check("tbl_tone", 32'(tone_on), 32'd1);
            run_idle();
            check("tbl_ngrants", 32'(glog.size()), 32'(tbl[i].ngr));
            check("tbl_last_grant", 32'(last_grant()), 32'(tbl[i].glast));
        end

        // Melody request twenty cycles into a brick-hit note.
        glog.delete();
        tick(1'b1, 4'b0010);
        tick(1'b1, 4'b0);
        repeat (19) tick(1'b1, 4'b0);
        tick(1'b1, 4'b1000);
        run_idle();
        check("preempt_grants", 32'(log_pack()), 32'h2800);

        // Requests during a melody are queued once each and never cut it short.
        glog.delete();
        tick(1'b1, 4'b1000);
        tick(1'b1, 4'b0);
        repeat (30) tick(1'b1, 4'b0);
        tick(1'b1, 4'b1000);
        repeat (10) tick(1'b1, 4'b0);
        tick(1'b1, 4'b0001);
        tick(1'b1, 4'b0001);
        repeat (100) tick(1'b1, 4'b0);
        tick(1'b1, 4'b0001);
        run_idle();
        check("melody_queue", 32'(log_pack()), 32'h8810);

        // Mute during GAP with a request pending, then requests while muted.
        tick(1'b1, 4'b0100);
        tick(1'b1, 4'b0);
        repeat (10) tick(1'b1, 4'b0);
        tick(1'b1, 4'b0100);
        repeat (55) tick(1'b1, 4'b0);
        check("mute_in_gap_tone", 32'(tone_on), 32'd0);
        tick(1'b0, 4'b0);
        check("mute_busy", 32'(busy), 32'd0);
        check("mute_addr", 32'(sample_addr), 32'd0);
        tick(1'b0, 4'b0100);
        tick(1'b0, 4'b0001);
        glog.delete();
        repeat (20) tick(1'b1, 4'b0);
        check("mute_no_grant", 32'(glog.size()), 32'd0);

        // Asynchronous reset in the middle of a note.
        tick(1'b1, 4'b0010);
        repeat (21) tick(1'b1, 4'b0);
        #1 reset_button = 1'b0;
        #1 check("async_reset", 32'({grant, note, sample_addr, sample_strobe, tone_on, busy}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_button = 1'b1;
        m_reset();
        repeat (10) tick(1'b1, 4'b0);
        check("post_reset_busy", 32'(busy), 32'd0);

        // Address wrap on the long-note instance.
        cnt = 0;
        req_w = 4'b0001;
        tick(1'b1, 4'b0);
        req_w = 4'b0;
        for (int i = 0; i < 260; i++) begin
            tick(1'b1, 4'b0);
            if (sample_strobe_w) begin
                cnt++;
                check("wrap_addr", 32'(sample_addr_w), 32'(cnt % 32));
            end
        end
        check("wrap_strobes", 32'(cnt), 32'd49);
        check("wrap_final_addr", 32'(sample_addr_w), 32'd17);
        check("wrap_busy", 32'(busy_w), 32'd0);

        // Random traffic with occasional mutes.
        for (int i = 0; i < 3000; i++) begin
            logic       en;
            logic [3:0] r;
            en = ($urandom_range(0, 149) != 0);
            r = 4'b0;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 59) == 0) r[b] = 1'b1;
            tick(en, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
